// File: rtl/wb_mem_arbiter.sv
// Two-master, one-slave Wishbone arbiter for the shared memory map.
// Round-robin grant (registered), access held until slave ack, abort or
// watchdog expiry, followed by a one-cycle release state before re-arbitration.
module wb_mem_arbiter #(
  parameter int AW      = 20,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  input  logic          m0_we_i,
  input  logic          m0_byte_i,
  input  logic          m0_stb_i,
  output logic          m0_ack_o,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  input  logic          m1_we_i,
  input  logic          m1_byte_i,
  input  logic          m1_stb_i,
  output logic          m1_ack_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  output logic          s_we_o,
  output logic          s_byte_o,
  output logic          s_stb_o,
  input  logic          s_ack_i,
  output logic          tout_o,
  output logic [1:0]    gnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2,
    ST_REL   = 2'd3
  } state_t;

  // The watchdog count is the number of BUSY cycles already completed, so the
  // TIMEOUT-th BUSY cycle is the one where the count equals TIMEOUT-1.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_last;      // last-served master: 1'b0 = m0, 1'b1 = m1
  logic [15:0] r_cnt;

  logic w_hit;
  logic w_done0;
  logic w_done1;
  logic w_tout0;
  logic w_tout1;

  assign w_hit   = (r_cnt == CNT_LAST);
  // An access completes on a real ack or on watchdog expiry, only while its strobe is held.
  assign w_done0 = (r_state == ST_BUSY0) && m0_stb_i && (s_ack_i || w_hit);
  assign w_done1 = (r_state == ST_BUSY1) && m1_stb_i && (s_ack_i || w_hit);
  // A real ack in the expiry cycle wins over the watchdog.
  assign w_tout0 = (r_state == ST_BUSY0) && m0_stb_i && w_hit && !s_ack_i;
  assign w_tout1 = (r_state == ST_BUSY1) && m1_stb_i && w_hit && !s_ack_i;

  // State register with asynchronous reset to IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: arbitration in IDLE, completion/abort detection in BUSYx.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_stb_i && m1_stb_i) begin
          w_next = r_last ? ST_BUSY0 : ST_BUSY1;
        end else if (m0_stb_i) begin
          w_next = ST_BUSY0;
        end else if (m1_stb_i) begin
          w_next = ST_BUSY1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_BUSY0: begin
        if (!m0_stb_i || w_done0) begin
          w_next = ST_REL;
        end else begin
          w_next = ST_BUSY0;
        end
      end
      ST_BUSY1: begin
        if (!m1_stb_i || w_done1) begin
          w_next = ST_REL;
        end else begin
          w_next = ST_BUSY1;
        end
      end
      ST_REL:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Last-served pointer: updated on ack or watchdog termination, not on abort.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last <= 1'b1;
    end else if (w_done0) begin
      r_last <= 1'b0;
    end else if (w_done1) begin
      r_last <= 1'b1;
    end else begin
      r_last <= r_last;
    end
  end

  // Watchdog counter: cleared while idle, counts every BUSY cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= 16'd0;
    end else if ((r_state == ST_BUSY0) || (r_state == ST_BUSY1)) begin
      r_cnt <= (r_cnt == 16'hFFFF) ? r_cnt : (r_cnt + 16'd1);
    end else begin
      r_cnt <= 16'd0;
    end
  end

  // Output muxing: slave side from the granted master, ack/data back to it only.
  // The slave strobe depends on state, master strobe and the counter only,
  // never on s_ack_i.
  always_comb begin
    s_adr_o  = {AW{1'b0}};
    s_dat_o  = {DW{1'b0}};
    s_we_o   = 1'b0;
    s_byte_o = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_dat_o = {DW{1'b0}};
    m1_dat_o = {DW{1'b0}};
    tout_o   = 1'b0;
    gnt_o    = 2'b00;
    case (r_state)
      ST_BUSY0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_byte_o = m0_byte_i;
        s_stb_o  = m0_stb_i && !w_hit;
        m0_ack_o = w_done0;
        m0_dat_o = w_tout0 ? {DW{1'b1}} : s_dat_i;
        tout_o   = w_tout0;
        gnt_o    = 2'b01;
      end
      ST_BUSY1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_byte_o = m1_byte_i;
        s_stb_o  = m1_stb_i && !w_hit;
        m1_ack_o = w_done1;
        m1_dat_o = w_tout1 ? {DW{1'b1}} : s_dat_i;
        tout_o   = w_tout1;
        gnt_o    = 2'b10;
      end
      ST_IDLE: gnt_o = 2'b00;
      ST_REL:  gnt_o = 2'b00;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter (TIMEOUT=8). Stimulus pushes the expected
// completion of every access into a queue; a monitor pops one entry per ack.
module tb_wb_mem_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic          m0_we_i, m0_byte_i, m0_stb_i, m0_ack_o;
  logic          m1_we_i, m1_byte_i, m1_stb_i, m1_ack_o;
  logic          s_we_o, s_byte_o, s_stb_o, s_ack_i, tout_o;
  logic [1:0]    gnt_o;

  wb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_we_i(m0_we_i), .m0_byte_i(m0_byte_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_we_i(m1_we_i), .m1_byte_i(m1_byte_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o),
    .s_byte_o(s_byte_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i),
    .tout_o(tout_o), .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  // Slave model: acks after slv_delay completed BUSY cycles (large = never).
  int         slv_delay = 100;
  logic [7:0] slv_cnt;
  assign s_ack_i = (gnt_o != 2'b00) && (slv_cnt == 8'(slv_delay));

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) slv_cnt <= 8'd0;
    else if ((gnt_o != 2'b00) && !s_ack_i) slv_cnt <= slv_cnt + 8'd1;
    else slv_cnt <= 8'd0;
  end

  typedef struct {
    int          m;
    logic [15:0] dat;
    logic        tout;
    logic [1:0]  gnt;
    logic [19:0] adr;
    logic [15:0] wdat;
    logic        we;
    logic        byt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic push(input int m, input logic [15:0] dat, input logic tout,
                      input logic [19:0] adr, input logic [15:0] wdat,
                      input logic we, input logic byt);
    exp_t e;
    e.m = m; e.dat = dat; e.tout = tout; e.gnt = (m == 0) ? 2'b01 : 2'b10;
    e.adr = adr; e.wdat = wdat; e.we = we; e.byt = byt;
    exp_q.push_back(e);
  endtask

  // Monitor: every ack (or tout pulse) is matched against the next expected completion.
  always @(negedge clk) begin
    if (!rst_i && (m0_ack_o || m1_ack_o || tout_o)) begin
      exp_t e;
      check("single_ack", {31'd0, m0_ack_o && m1_ack_o}, 32'd0);
      check("tout_has_ack", {31'd0, tout_o && !(m0_ack_o || m1_ack_o)}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack_master", {30'd0, m1_ack_o, m0_ack_o}, (e.m == 0) ? 32'd1 : 32'd2);
        check("ack_data", {16'd0, (e.m == 0) ? m0_dat_o : m1_dat_o}, {16'd0, e.dat});
        check("other_dat_zero", {16'd0, (e.m == 0) ? m1_dat_o : m0_dat_o}, 32'd0);
        check("tout", {31'd0, tout_o}, {31'd0, e.tout});
        check("gnt_at_ack", {30'd0, gnt_o}, {30'd0, e.gnt});
        check("s_adr", {12'd0, s_adr_o}, {12'd0, e.adr});
        check("s_dat", {16'd0, s_dat_o}, {16'd0, e.wdat});
        check("s_we_byte", {30'd0, s_we_o, s_byte_o}, {30'd0, e.we, e.byt});
      end
    end
  end

  // Waits (bounded) for an ack to master m; reports BUSY cycles seen and s_stb_o at the ack.
  task automatic wait_ack(input int m, output int n_busy, output logic stb_at);
    bit seen = 1'b0;
    n_busy = 0;
    stb_at = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (gnt_o != 2'b00) n_busy++;
      if ((m == 0) ? m0_ack_o : m1_ack_o) begin
        seen = 1'b1;
        stb_at = s_stb_o;
      end
    end
    if (!seen) check("ack_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input logic [1:0] g);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (gnt_o == g) seen = 1'b1;
    end
    if (!seen) check("gnt_wait_expired", {30'd0, gnt_o}, {30'd0, g});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int   nb;
    int   acks;
    logic sa;

    rst_i = 1'b1;
    m0_adr_i = 20'h0; m0_dat_i = 16'h0; m0_we_i = 1'b0; m0_byte_i = 1'b0; m0_stb_i = 1'b0;
    m1_adr_i = 20'h0; m1_dat_i = 16'h0; m1_we_i = 1'b0; m1_byte_i = 1'b0; m1_stb_i = 1'b0;
    s_dat_i = 16'h0;

    // Reset state, even with both strobes requesting.
    m0_stb_i = 1'b1; m1_stb_i = 1'b1; m0_adr_i = 20'hABCDE;
    repeat (2) @(negedge clk);
    check("rst_stb", {31'd0, s_stb_o}, 32'd0);
    check("rst_gnt", {30'd0, gnt_o}, 32'd0);
    check("rst_acks", {29'd0, m0_ack_o, m1_ack_o, tout_o}, 32'd0);
    check("rst_adr", {12'd0, s_adr_o}, 32'd0);
    check("rst_we_byte", {30'd0, s_we_o, s_byte_o}, 32'd0);
    m0_stb_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();

    // Single m0 read, slave acks two cycles after strobe.
    slv_delay = 2; s_dat_i = 16'h1234;
    m0_adr_i = 20'h00400; m0_dat_i = 16'h0000; m0_we_i = 1'b0;
    push(0, 16'h1234, 1'b0, 20'h00400, 16'h0000, 1'b0, 1'b0);
    m0_stb_i = 1'b1;
    @(negedge clk);
    check("rd_arb_latency_stb", {31'd0, s_stb_o}, 32'd0);
    @(negedge clk);
    check("rd_stb_rise", {31'd0, s_stb_o}, 32'd1);
    check("rd_gnt", {30'd0, gnt_o}, 32'd1);
    wait_ack(0, nb, sa);
    check("rd_ack_cycle", nb, 32'd2);
    tick();
    m0_stb_i = 1'b0;
    @(negedge clk);
    check("rd_rel_gnt", {30'd0, gnt_o}, 32'd0);
    check("rd_rel_stb", {31'd0, s_stb_o}, 32'd0);
    tick();

    // Pointer back to reset value, then both masters hold strobe: 01,10,01,10.
    rst_i = 1'b1; tick(); rst_i = 1'b0; tick();
    slv_delay = 0; s_dat_i = 16'h5A5A;
    m0_adr_i = 20'h00010; m1_adr_i = 20'h00020; m0_dat_i = 16'h0000; m1_dat_i = 16'h0000;
    push(0, 16'h5A5A, 1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0);
    push(1, 16'h5A5A, 1'b0, 20'h00020, 16'h0000, 1'b0, 1'b0);
    push(0, 16'h5A5A, 1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0);
    push(1, 16'h5A5A, 1'b0, 20'h00020, 16'h0000, 1'b0, 1'b0);
    m0_stb_i = 1'b1; m1_stb_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 60 && acks < 4; i++) begin
      @(negedge clk);
      if (m0_ack_o || m1_ack_o) acks++;
    end
    check("rr_ack_count", acks, 32'd4);
    tick();
    m0_stb_i = 1'b0; m1_stb_i = 1'b0;
    repeat (2) tick();

    // Byte write by m1 while m0 presents different (idle) values.
    slv_delay = 1; s_dat_i = 16'hC0DE;
    m0_adr_i = 20'h11111; m0_dat_i = 16'h2222; m0_we_i = 1'b0; m0_byte_i = 1'b0;
    m1_adr_i = 20'hB8000; m1_dat_i = 16'h00AB; m1_we_i = 1'b1; m1_byte_i = 1'b1;
    push(1, 16'hC0DE, 1'b0, 20'hB8000, 16'h00AB, 1'b1, 1'b1);
    m1_stb_i = 1'b1;
    wait_ack(1, nb, sa);
    tick();
    m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_byte_i = 1'b0;
    repeat (2) tick();

    // Watchdog: slave never acks, forced termination in the 8th BUSY cycle.
    slv_delay = 100; s_dat_i = 16'h1357;
    m0_adr_i = 20'h00400; m0_dat_i = 16'h0000;
    push(0, 16'hFFFF, 1'b1, 20'h00400, 16'h0000, 1'b0, 1'b0);
    m0_stb_i = 1'b1;
    wait_ack(0, nb, sa);
    check("wd_busy_cycles", nb, 32'd8);
    check("wd_stb_low", {31'd0, sa}, 32'd0);
    tick();
    m0_stb_i = 1'b0;
    repeat (2) tick();

    // Real ack in the 8th BUSY cycle beats the watchdog.
    slv_delay = 7; s_dat_i = 16'h7777;
    push(0, 16'h7777, 1'b0, 20'h00400, 16'h0000, 1'b0, 1'b0);
    m0_stb_i = 1'b1;
    wait_ack(0, nb, sa);
    check("wd_race_busy_cycles", nb, 32'd8);
    tick();
    m0_stb_i = 1'b0;
    repeat (2) tick();

    // Abort: m1 drops strobe one cycle into BUSY1, no ack is delivered.
    slv_delay = 100;
    m1_adr_i = 20'h00777; m1_stb_i = 1'b1;
    wait_gnt(2'b10);
    tick();
    m1_stb_i = 1'b0;
    @(negedge clk);
    check("abort_still_busy", {30'd0, gnt_o}, 32'd2);
    check("abort_stb_low", {31'd0, s_stb_o}, 32'd0);
    @(negedge clk);
    check("abort_rel", {29'd0, gnt_o, m1_ack_o}, 32'd0);
    @(negedge clk);
    check("abort_idle", {29'd0, gnt_o, m1_ack_o}, 32'd0);
    tick();

    // Asynchronous reset during BUSY0: outputs drop before the next clock edge.
    m0_adr_i = 20'h00123; m0_stb_i = 1'b1;
    wait_gnt(2'b01);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_stb", {31'd0, s_stb_o}, 32'd0);
    check("async_rst_gnt", {30'd0, gnt_o}, 32'd0);
    check("async_rst_ack", {31'd0, m0_ack_o}, 32'd0);
    m0_stb_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b0;
    tick();

    // After reset the pointer favours m0 again on a tie.
    slv_delay = 0; s_dat_i = 16'hBEEF;
    m1_adr_i = 20'h00321;
    push(0, 16'hBEEF, 1'b0, 20'h00123, 16'h0000, 1'b0, 1'b0);
    m0_stb_i = 1'b1; m1_stb_i = 1'b1;
    wait_ack(0, nb, sa);
    tick();
    m0_stb_i = 1'b0; m1_stb_i = 1'b0;
    repeat (3) tick();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter in front of the shared memory map (SRAM/flash controller).
- Lets the CPU (master 0) and a second bus master (master 1, a DMA or display fetch engine) share the single memory slave.
- Grant is round-robin with registered selection, and each granted access runs until the slave acks.
- A watchdog terminates accesses the slave never acks, so the CPU cannot hang.

Parameters:
- AW, 20, address width.
- DW, 16, data width.
- TIMEOUT, 255, max cycles a granted access waits for slave ack before forced termination (must be 1..65535).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous active-high reset
- m0_adr_i  input  AW  master 0 address
- m0_dat_i  input  DW  master 0 write data
- m0_dat_o  output  DW  master 0 read data
- m0_we_i  input  1  master 0 write enable
- m0_byte_i  input  1  master 0 byte access
- m0_stb_i  input  1  master 0 strobe (request)
- m0_ack_o  output  1  master 0 acknowledge
- m1_adr_i, m1_dat_i, m1_dat_o, m1_we_i, m1_byte_i, m1_stb_i, m1_ack_o  same as master 0, for master 1
- s_adr_o  output  AW  slave address
- s_dat_o  output  DW  slave write data
- s_dat_i  input  DW  slave read data
- s_we_o  output  1  slave write enable
- s_byte_o  output  1  slave byte access
- s_stb_o  output  1  slave strobe
- s_ack_i  input  1  slave acknowledge
- tout_o  output  1  one-cycle pulse on watchdog termination
- gnt_o  output  2  one-hot current grant (debug)

Behaviour:
- States: IDLE, BUSY0, BUSY1, REL.
- Reset state: IDLE; last-served pointer = master 1, so master 0 wins the first tie. All outputs 0 during reset: stb, acks, tout_o, gnt_o, slave address/data/we/byte.
- IDLE:
  - m0 only requesting -> BUSY0; m1 only -> BUSY1.
  - Both requesting -> grant goes to the master not last served.
  - No request -> stay in IDLE.
  - The grant is registered, so s_stb_o first rises the cycle after the request is seen in IDLE (1-cycle arbitration latency).
- BUSYx:
  - s_adr/dat/we/byte_o are muxed from master x.
  - s_stb_o = mx_stb_i (combinational, gated by state).
  - mx_ack_o = s_ack_i; mx_dat_o = s_dat_i.
  - The non-granted master sees ack=0 and dat_o=0.
  - When s_ack_i=1 -> REL; last-served pointer <= x.
  - Master x dropping stb before ack (abort) -> REL; no ack is delivered.
- Watchdog:
  - A 16-bit counter clears on entering BUSYx and increments each BUSYx cycle without ack.
  - When the count reaches TIMEOUT:
    - mx_ack_o=1 that cycle;
    - mx_dat_o=16'hFFFF;
    - s_stb_o=0;
    - tout_o=1 for that one cycle;
    - next state -> REL; pointer updated as for a normal ack.
  - If s_ack_i arrives in the same cycle the count reaches TIMEOUT, the real ack wins: real data is returned and tout_o=0.
- REL:
  - Lasts exactly one cycle; s_stb_o=0 and all acks=0.
  - Gives the master time to drop stb, so a held strobe cannot trigger a second access.
  - Then -> IDLE, where arbitration resumes (a master still holding stb in IDLE is treated as a new request).
  - Back-to-back accesses by one master, with the other idle, cost 1 (REL) + 1 (IDLE) cycles of overhead.
- gnt_o: 2'b01 in BUSY0, 2'b10 in BUSY1, 0 otherwise.
- Asynchronous reset mid-access: state is forced to IDLE immediately, s_stb_o and acks drop without waiting for the clock, and the pointer returns to its reset value.
- No combinational path exists from s_ack_i to any strobe output. The data and ack paths are purely combinational muxes.

Test Plan:
- Single m0 read: m0_stb_i=1, adr=20'h00400, slave acks 2 cycles after s_stb_o with 16'h1234 -> s_stb_o rises 1 cycle after request; m0_ack_o and m0_dat_o=16'h1234 arrive in the slave-ack cycle; then REL, then IDLE; m1_ack_o stays 0.
- Simultaneous requests from reset: both stb=1 -> m0 served first, then m1 (gnt_o 01 then 10). With both held and the slave acking at once, grants alternate 01,10,01,10.
- Byte write by m1: adr=20'hB8000, dat=16'h00AB, byte=1 -> s_adr/dat/we/byte_o exactly match m1 while gnt_o=2'b10.
- Watchdog: TIMEOUT=8, slave never acks -> m0_ack_o=1 with dat 16'hFFFF and tout_o=1 in the 8th BUSY cycle; s_stb_o=0 that cycle. Repeat with s_ack_i arriving in the 8th cycle -> real data returned, tout_o=0.
- Abort: m1 drops stb 1 cycle into BUSY1 with no ack -> REL then IDLE; no m1_ack_o is delivered.
- Reset mid-access: assert rst_i asynchronously during BUSY0 -> s_stb_o and gnt_o go to 0 before the next clock edge; after release, a tie is again won by m0.
